// File: rtl/piso_serializer.sv
// Parallel-in / serial-out shifter with a valid/ready load port and a
// stallable shift_en consumer, supporting back-to-back frames.
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] par_data,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             shift_en,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_start,
  output logic             frame_done,
  output logic             busy
);

  localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic             done_q;
  logic [WIDTH-1:0] shifted;

  // Shift toward whichever end feeds ser_out, zero-filling behind.
  assign shifted = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};

  // Ready in IDLE, or exactly when the last bit is being consumed.
  assign load_ready  = (state == IDLE) || ((cnt == '0) && shift_en);
  assign busy        = (state == SHIFT);
  assign ser_valid   = busy;
  assign ser_out     = busy & (MSB_FIRST ? shreg[WIDTH-1] : shreg[0]);
  assign frame_start = busy && (cnt == LAST_CNT);
  assign frame_done  = done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      shreg  <= '0;
      cnt    <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (load_valid) begin
            shreg <= par_data;
            cnt   <= LAST_CNT;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (shift_en) begin
            if (cnt == '0) begin
              done_q <= 1'b1;
              if (load_valid) begin
                shreg <= par_data;
                cnt   <= LAST_CNT;
              end else begin
                shreg <= '0;
                state <= IDLE;
              end
            end else begin
              shreg <= shifted;
              cnt   <= cnt - 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/piso_serializer.md
PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 Parameter WIDTH, default 8: parallel word width, legal range 2..32.
REQ-002 Parameter MSB_FIRST, default 1: 1 = bit WIDTH-1 sent first; 0 = bit 0 sent first.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 par_data  input  WIDTH  parallel word to transmit.
REQ-006 load_valid  input  1  par_data is valid this cycle.
REQ-007 load_ready  output  1  serializer accepts a word this cycle.
REQ-008 shift_en  input  1  downstream consumes the current ser_out bit at this posedge.
REQ-009 ser_out  output  1  current serial bit.
REQ-010 ser_valid  output  1  ser_out holds a frame bit.
REQ-011 frame_start  output  1  ser_out is the first bit of a frame.
REQ-012 frame_done  output  1  one-cycle pulse after the last bit is consumed.
REQ-013 busy  output  1  a frame is in progress (state SHIFT).

Function
REQ-014 The FSM SHALL have two states: IDLE and SHIFT.
REQ-015 Load handshake SHALL occur when load_valid and load_ready are both 1 at a posedge.
  - par_data captured into shift register.
  - Bit counter set to WIDTH-1.
  - State becomes SHIFT.
REQ-016 load_ready SHALL be combinational.
  - 1 in IDLE.
  - 1 in SHIFT only when counter == 0 and shift_en == 1.
  - 0 otherwise.
REQ-017 In SHIFT, ser_valid SHALL be 1, and ser_out SHALL be the shift-register MSB (MSB_FIRST=1) or LSB (MSB_FIRST=0), driven from registers only.
REQ-018 In IDLE, ser_valid SHALL be 0 and ser_out SHALL be 0.
REQ-019 In SHIFT with shift_en=1 and counter>0, each posedge SHALL shift the register by one toward the output end (zero-filled) and decrement the counter.
REQ-020 In SHIFT with shift_en=0, the shift register, counter and ser_out SHALL hold (stall), with no bit lost or repeated.
REQ-021 frame_start SHALL be 1 while in SHIFT and counter == WIDTH-1 and no bit of the current frame has been consumed; it holds through stalls.
REQ-022 Last bit (SHIFT, counter == 0, shift_en=1) SHALL behave as follows:
  - frame_done is registered high for exactly the next cycle.
  - Without a simultaneous load, state becomes IDLE.
  - With a simultaneous load, the new word is captured and state stays SHIFT (back-to-back, no idle gap).
REQ-023 Latency SHALL be:
  - First bit on ser_out in the cycle after the accepting edge.
  - A frame with no stalls occupies exactly WIDTH cycles.
REQ-024 load_valid while load_ready=0 SHALL be ignored, with no capture and no state change.
REQ-025 busy SHALL equal (state == SHIFT).

Reset
REQ-026 While rst_n=0, the block SHALL asynchronously force:
  - state IDLE, shift register 0, counter 0;
  - ser_out=0, ser_valid=0, frame_start=0, frame_done=0, busy=0, load_ready=1.
REQ-027 Reset asserted mid-frame SHALL abandon the frame immediately: no frame_done, and the partial word is discarded.
REQ-028 After rst_n deassertion, the first posedge SHALL accept a load if load_valid=1.

Verification
REQ-029 MSB_FIRST=1, WIDTH=8: load 0xA5, shift_en=1 constantly -> ser_out 1,0,1,0,0,1,0,1 on 8 consecutive cycles; frame_start only on the first; frame_done one cycle after the 8th; busy low.
REQ-030 MSB_FIRST=0: load 0xA5 -> ser_out 1,0,1,0,0,1,0,1 (LSB first); load 0x01 -> 1,0,0,0,0,0,0,0.
REQ-031 Stall: load 0xC3, drop shift_en for 3 cycles after bit 2 -> ser_out holds 0 for those cycles; full sequence 1,1,0,0,0,0,1,1 intact; frame takes 11 cycles.
REQ-032 Back-to-back: load 0xFF, hold load_valid with 0x00 ready -> load_ready high only on the last-bit cycle; 16 contiguous ser_valid cycles (8 ones, then 8 zeros); frame_done pulses after the 8th and after the 16th bit; frame_start after bit 8.
REQ-033 Ignored load: in SHIFT at counter=5, present load_valid=1 with 0x3C -> no capture; the current frame completes unchanged.
REQ-034 Reset mid-frame: assert rst_n=0 after bit 4 of 0x5A -> all outputs take REQ-026 values without a clock edge; no frame_done; a new load of 0x81 after release serializes correctly.
